// File: rtl/uart_rx_core_pkg.sv
// Shared UART configuration types and the receiver FSM state encoding.
// Normalisation helpers map out-of-range configuration values onto legal settings.
package uart_rx_core_pkg;

    typedef enum logic [4:0] {
        X16 = 5'd16,
        X13 = 5'd13
    } OverSamplingE;

    typedef enum logic [1:0] {
        ONE_BIT = 2'd1,
        TWO_BIT = 2'd2
    } StopBitE;

    typedef enum logic [3:0] {
        FIVE_BIT  = 4'd5,
        SIX_BIT   = 4'd6,
        SEVEN_BIT = 4'd7,
        EIGHT_BIT = 4'd8
    } DataBitsE;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    function automatic OverSamplingE norm_os(input logic [4:0] v);
        return (v == 5'd13) ? X13 : X16;
    endfunction

    function automatic DataBitsE norm_bits(input logic [3:0] v);
        if (v < 4'd5) return FIVE_BIT;
        if (v > 4'd8) return EIGHT_BIT;
        return DataBitsE'(v);
    endfunction

    function automatic StopBitE norm_stop(input logic [1:0] v);
        return (v == 2'd2) ? TWO_BIT : ONE_BIT;
    endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Free-running oversample tick generator: one-cycle tick every divisor clocks.
// A divisor of 0 behaves as 1; resync restarts the count from 0 without a tick.
module uart_baud_tick_gen #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DIV_WIDTH-1:0] divisor_i,
    input  logic                 resync_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] last;

    always_comb begin
        last   = (divisor_i == '0) ? '0 : divisor_i - DIV_WIDTH'(1);
        cnt_d  = cnt_q + DIV_WIDTH'(1);
        tick_o = 1'b0;
        if (resync_i) begin
            cnt_d = '0;
        end else if (cnt_q >= last) begin
            cnt_d  = '0;
            tick_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with majority-vote bit decisions, parity/framing
// status and a valid/ready output holding register.
module uart_rx_core import uart_rx_core_pkg::*; #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rxd_i,
    input  logic [DIV_WIDTH-1:0]  cfg_baud_divisor_i,
    input  logic [4:0]            cfg_over_sampling_i,
    input  logic [3:0]            cfg_data_bits_i,
    input  logic                  cfg_parity_enable_i,
    input  logic                  cfg_parity_odd_i,
    input  logic [1:0]            cfg_stop_bits_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  parity_error_o,
    output logic                  framing_error_o,
    output logic                  overrun_error_o,
    output logic                  busy_o
);

    logic rxd_sync1_q, rxd_sync2_q, rxd_prev_q;

    rx_state_e       state_q, state_d;
    logic [4:0]      sample_q, sample_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic            stop_cnt_q, stop_cnt_d;
    logic [1:0]      maj_s_q, maj_s_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;

    OverSamplingE    os_q, os_d;
    DataBitsE        nbits_q, nbits_d;
    StopBitE         stop_q, stop_d;
    logic            par_en_q, par_en_d;
    logic            par_odd_q, par_odd_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;

    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            parity_err_q, parity_err_d;
    logic            framing_err_q, framing_err_d;
    logic            overrun_q, overrun_d;

    logic            tick, start_edge, at_decide, maj, complete, accept;
    logic [4:0]      os_val, os_last, mid;
    logic [3:0]      nbits_val;
    logic [DIV_WIDTH-1:0] div_sel;

    assign start_edge = (state_q == StIdle) && rxd_prev_q && !rxd_sync2_q;
    // Idle uses the live divisor; a running frame keeps the one latched at its start.
    assign div_sel    = (state_q == StIdle) ? cfg_baud_divisor_i : div_q;

    uart_baud_tick_gen #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_tick_gen (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .divisor_i(div_sel),
        .resync_i (start_edge),
        .tick_o   (tick)
    );

    assign os_val    = os_q;
    assign os_last   = os_val - 5'd1;
    assign mid       = os_val >> 1;
    assign nbits_val = nbits_q;
    assign at_decide = tick && (sample_q == mid + 5'd1);
    assign maj       = (maj_s_q[0] & maj_s_q[1]) | (maj_s_q[0] & rxd_sync2_q) |
                       (maj_s_q[1] & rxd_sync2_q);

    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        maj_s_d    = maj_s_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        os_d       = os_q;
        nbits_d    = nbits_q;
        stop_d     = stop_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        div_d      = div_q;
        complete   = 1'b0;

        if (state_q == StIdle) begin
            sample_d = '0;
        end else if (tick) begin
            sample_d = (sample_q == os_last) ? 5'd0 : sample_q + 5'd1;
        end
        if (tick && sample_q == mid - 5'd1) maj_s_d[0] = rxd_sync2_q;
        if (tick && sample_q == mid)        maj_s_d[1] = rxd_sync2_q;

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d    = StStart;
                    sample_d   = '0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    shift_d    = '0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    os_d       = norm_os(cfg_over_sampling_i);
                    nbits_d    = norm_bits(cfg_data_bits_i);
                    stop_d     = norm_stop(cfg_stop_bits_i);
                    par_en_d   = cfg_parity_enable_i;
                    par_odd_d  = cfg_parity_odd_i;
                    div_d      = cfg_baud_divisor_i;
                end
            end
            StStart: begin
                if (at_decide) state_d = maj ? StIdle : StData;
            end
            StData: begin
                if (at_decide) begin
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (bit_cnt_q == 4'(i)) shift_d[i] = maj;
                    end
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == nbits_val - 4'd1) state_d = par_en_q ? StParity : StStop;
                end
            end
            StParity: begin
                if (at_decide) begin
                    perr_d  = ((^shift_q) ^ maj) != par_odd_q;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (at_decide) begin
                    ferr_d = ferr_q | ~maj;
                    // Complete at the last stop bit's decision so a new start can follow.
                    if (stop_cnt_q == (stop_q == TWO_BIT)) begin
                        complete = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign accept = rx_valid_q & rx_ready_i;

    always_comb begin
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        parity_err_d  = parity_err_q;
        framing_err_d = framing_err_q;
        overrun_d     = 1'b0;
        if (complete && (!rx_valid_q || accept)) begin
            rx_data_d     = shift_q;
            parity_err_d  = perr_q;
            framing_err_d = ferr_d;
            rx_valid_d    = 1'b1;
        end else if (complete) begin
            overrun_d = 1'b1;
        end else if (accept) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rxd_sync1_q   <= 1'b1;
            rxd_sync2_q   <= 1'b1;
            rxd_prev_q    <= 1'b1;
            state_q       <= StIdle;
            sample_q      <= '0;
            bit_cnt_q     <= '0;
            stop_cnt_q    <= 1'b0;
            maj_s_q       <= '0;
            shift_q       <= '0;
            perr_q        <= 1'b0;
            ferr_q        <= 1'b0;
            os_q          <= X16;
            nbits_q       <= EIGHT_BIT;
            stop_q        <= ONE_BIT;
            par_en_q      <= 1'b0;
            par_odd_q     <= 1'b0;
            div_q         <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            rxd_sync1_q   <= rxd_i;
            rxd_sync2_q   <= rxd_sync1_q;
            rxd_prev_q    <= rxd_sync2_q;
            state_q       <= state_d;
            sample_q      <= sample_d;
            bit_cnt_q     <= bit_cnt_d;
            stop_cnt_q    <= stop_cnt_d;
            maj_s_q       <= maj_s_d;
            shift_q       <= shift_d;
            perr_q        <= perr_d;
            ferr_q        <= ferr_d;
            os_q          <= os_d;
            nbits_q       <= nbits_d;
            stop_q        <= stop_d;
            par_en_q      <= par_en_d;
            par_odd_q     <= par_odd_d;
            div_q         <= div_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            parity_err_q  <= parity_err_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx_data_o       = rx_data_q;
    assign rx_valid_o      = rx_valid_q;
    assign parity_error_o  = parity_err_q;
    assign framing_error_o = framing_err_q;
    assign overrun_error_o = overrun_q;
    assign busy_o          = (state_q != StIdle);

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Oversampling UART receiver. Converts the serial line `rxd` into parallel characters and presents them on a valid/ready handshake with per-character parity and framing status. It is the receive-side RTL counterpart to the UART transmit path and consumes the shared UART configuration types. Runtime configuration covers data width 5–8, optional odd/even parity, 1 or 2 stop bits, and x16 or x13 oversampling.

## Interface
- `DATA_WIDTH`, 8: width of `rxData`; the maximum character length.
- `DIV_WIDTH`, 16: width of the baud divisor.
- `clk` input 1: single clock domain.
- `reset` input 1: asynchronous, active-low reset.
- `rxd` input 1: serial line, asynchronous to `clk`, idle high.
- `cfgBaudDivisor` input DIV_WIDTH: number of `clk` cycles per oversample tick. A value of 0 is treated as 1.
- `cfgOverSampling` input 5: samples per bit, 16 or 13. Any other value is treated as 16.
- `cfgDataBits` input 4: character length, 5..8. Values below 5 are treated as 5; values above 8 are treated as 8.
- `cfgParityEnable` input 1: a parity bit follows the data bits.
- `cfgParityOdd` input 1: 1 selects odd parity, 0 selects even.
- `cfgStopBits` input 2: 1 or 2 stop bits. Any other value is treated as 1.
- `rxData` output DATA_WIDTH: received character, LSB-aligned. Unused upper bits are 0.
- `rxValid` output 1: `rxData` and its error flags are valid.
- `rxReady` input 1: the consumer accepts the character when `rxValid && rxReady`.
- `parityError` output 1: parity mismatch for the presented character.
- `framingError` output 1: at least one stop bit was sampled as 0 for the presented character.
- `overrunError` output 1: one-cycle pulse when a completed frame is dropped.
- `busy` output 1: a frame is in progress (FSM state is not IDLE).

## Operation
- `rxd` passes through a 2-flop synchronizer. Both flops reset to 1.
- **Tick generator:** counts 0..divisor-1 and emits a one-cycle `tick` at the wrap. It runs freely in all states. In IDLE it is resynchronized to 0 when a start edge is detected.
- **Config latching:** all `cfg*` inputs are latched at start detection. Changes during a frame take effect on the next frame.
- **Sample counter:** runs 0..OS-1 on each tick, where OS is the oversampling factor. MID = OS/2, giving 8 for x16 and 6 for x13.
- **Bit decision:** each bit value is the majority of 3 samples taken at counter values MID-1, MID and MID+1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** a falling edge on the synchronized `rxd` (previous 1, current 0) moves the FSM to START. A line held low never retriggers.
  - **START:** if the majority value is 1, the start is false and the FSM returns to IDLE with no output. Otherwise it moves to DATA.
  - **DATA:** shifts bits in LSB first. After `cfgDataBits` bits it moves to PARITY if parity is enabled, otherwise to STOP.
  - **PARITY:** the error condition is (XOR of data bits ^ parity bit) != `cfgParityOdd`.
  - **STOP:** samples 1 or 2 stop bits. After the last stop bit's MID+1 sample the frame completes and the FSM enters IDLE immediately, without waiting for the end of the bit. This allows back-to-back frames.
- **Frame completion:** load `rxData`, `parityError` and `framingError` together and set `rxValid`. A frame with errors is still delivered, with its flags set.
- **Handshake:** `rxValid` and the flags stay stable until `rxValid && rxReady`. In that cycle `rxValid` clears, unless a new completion occurs in the same cycle.
- **Completion while `rxValid=1` and `rxReady=0`:** the new frame is discarded, the held character is unchanged, and `overrunError` pulses for 1 cycle.
- **Completion in the same cycle as acceptance:** the new frame is loaded, `rxValid` stays 1, and no overrun is flagged.

## Timing
- **Reset values:** `rxValid`, `parityError`, `framingError`, `overrunError` and `busy` reset to 0. `rxData` resets to 0. FSM resets to IDLE, all counters to 0.
- **Reset assertion mid-frame:** takes effect immediately and asynchronously, and the frame is lost. After release, the receiver waits for a fresh falling edge.
- **Start-edge latency:** 2 synchronizer cycles plus 1 edge-detect cycle from the `rxd` falling edge to `busy`=1.
- **Completion latency:** `rxValid` rises 1 `clk` after the tick that carries the final stop-bit MID+1 sample.
- **Overrun pulse:** `overrunError` pulses in the same cycle that `rxValid` would have been reloaded.
- **Tick rate:** one bit lasts OS×divisor `clk` cycles.

## Structure
- **Shared package:**
  - `OverSamplingE` enum: X16=16, X13=13.
  - `StopBitE` enum: ONE_BIT=1, TWO_BIT=2.
  - `DataBitsE` enum, 4-bit: FIVE_BIT=5, SIX_BIT=6, SEVEN_BIT=7, EIGHT_BIT=8.
  - The FSM state enum.
- **Sub-module:** `uart_baud_tick_gen` contains the divisor counter, tick output and resync input. The synchronizer, FSM and output register stay in `uart_rx_core`.

## Test plan
- **8N1 frame:** divisor 1, x16, 8N1, frame 0xA5 sent at 16 clk/bit with `rxReady`=1 → `rxData`=0xA5 for one cycle, both error flags 0.
- **Parity error:** 7 data bits, even parity, data 0x41, parity bit driven 1 → `rxData`=0x41, `parityError`=1, `framingError`=0.
- **Framing error and break:** 8N1, data 0x3C, stop bit driven 0 → `framingError`=1. Then hold `rxd` low for 40 bit times → no further frames. On the next high-then-falling edge, a fresh frame 0x55 is received cleanly.
- **False start:** `rxd` low for 4 ticks, then high → no `rxValid`, `busy` returns to 0 after the START mid-sample.
- **Overrun:** `rxReady`=0, send frames 0x11 then 0x22 back to back → `rxData` holds 0x11 and `overrunError` pulses once. Raising `rxReady` then yields only 0x11.
- **x13, 5 data bits, 2 stop bits:** divisor 3, frame 0x15 → `rxData`=0x15 with upper 3 bits 0. An immediately following frame 0x0A with `rxReady`=1 in the completion cycle → both frames delivered, no overrun.
